// File: rtl/fetch_ctrl_if.sv
// Instruction-memory read port: req/ack handshake with address and returned instruction.
// master = fetch side (drives req/addr), slave = memory side (drives ack/rdata).
interface fetch_ctrl_if #(
    parameter int unsigned PC_W   = 6,
    parameter int unsigned INST_W = 16
) ();
    logic              req;
    logic [PC_W-1:0]   addr;
    logic              ack;
    logic [INST_W-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, reads imem over req/ack, loads IF/ID, handles stall and
// branch redirect. Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_ctrl #(
    parameter int unsigned          PC_W     = 6,
    parameter int unsigned          INST_W   = 16,
    parameter int unsigned          PC_STEP  = 2,
    parameter logic [PC_W-1:0]      RESET_PC = '0,
    parameter logic [INST_W-1:0]    NOP_INST = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    fetch_ctrl_if.master       imem,
    input  logic               i_stall,
    input  logic               i_redirect,
    input  logic [PC_W-1:0]    i_redirect_pc,
    output logic               o_ifid_valid,
    output logic [PC_W-1:0]    o_ifid_pcadd4,
    output logic [INST_W-1:0]  o_ifid_inst,
    output logic [15:0]        o_perf_fetch_cnt,
    output logic [15:0]        o_perf_stall_cnt
);

    typedef enum logic [0:0] {S_REQ, S_HOLD} state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic               r_req;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_d;
    logic [PC_W-1:0]    w_pc_inc;
    logic               r_valid;
    logic               w_valid_d;
    logic [PC_W-1:0]    r_pcadd4;
    logic [PC_W-1:0]    w_pcadd4_d;
    logic [INST_W-1:0]  r_inst;
    logic [INST_W-1:0]  w_inst_d;
    logic [PC_W-1:0]    r_hold_pcadd4;
    logic [PC_W-1:0]    w_hold_pcadd4_d;
    logic [INST_W-1:0]  r_hold_inst;
    logic [INST_W-1:0]  w_hold_inst_d;
    logic               w_ack_take;

    // Modulo 2^PC_W wrap falls out of the truncated add.
    assign w_pc_inc   = r_pc + PC_W'(PC_STEP);
    assign w_ack_take = (r_state == S_REQ) && r_req && imem.ack;

    always_comb begin
        w_state_d       = r_state;
        w_pc_d          = r_pc;
        w_valid_d       = r_valid;
        w_pcadd4_d      = r_pcadd4;
        w_inst_d        = r_inst;
        w_hold_pcadd4_d = r_hold_pcadd4;
        w_hold_inst_d   = r_hold_inst;

        if (i_redirect) begin
            // Flush wins over stall; any ack this cycle and the hold buffer are dropped.
            w_pc_d     = i_redirect_pc;
            w_valid_d  = 1'b0;
            w_pcadd4_d = i_redirect_pc;
            w_inst_d   = NOP_INST;
            w_state_d  = S_REQ;
        end else begin
            unique case (r_state)
                S_REQ: begin
                    if (w_ack_take) begin
                        w_pc_d = w_pc_inc;
                        if (!i_stall) begin
                            w_valid_d  = 1'b1;
                            w_pcadd4_d = w_pc_inc;
                            w_inst_d   = imem.rdata;
                        end else begin
                            w_hold_pcadd4_d = w_pc_inc;
                            w_hold_inst_d   = imem.rdata;
                            w_state_d       = S_HOLD;
                        end
                    end else if (!i_stall) begin
                        // ID consumed the entry and nothing new arrived: present a bubble.
                        w_valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!i_stall) begin
                        w_valid_d  = 1'b1;
                        w_pcadd4_d = r_hold_pcadd4;
                        w_inst_d   = r_hold_inst;
                        w_state_d  = S_REQ;
                    end
                end
                default: w_state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_REQ;
            r_req         <= 1'b0;
            r_pc          <= RESET_PC;
            r_valid       <= 1'b0;
            r_pcadd4      <= RESET_PC;
            r_inst        <= NOP_INST;
            r_hold_pcadd4 <= RESET_PC;
            r_hold_inst   <= NOP_INST;
        end else begin
            r_state       <= w_state_d;
            r_req         <= (w_state_d == S_REQ);
            r_pc          <= w_pc_d;
            r_valid       <= w_valid_d;
            r_pcadd4      <= w_pcadd4_d;
            r_inst        <= w_inst_d;
            r_hold_pcadd4 <= w_hold_pcadd4_d;
            r_hold_inst   <= w_hold_inst_d;
        end
    end

    assign imem.req      = r_req;
    assign imem.addr     = r_pc;
    assign o_ifid_valid  = r_valid;
    assign o_ifid_pcadd4 = r_pcadd4;
    assign o_ifid_inst   = r_inst;

`ifdef FETCH_PERF_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_stall_cnt;
    logic        w_fetch_evt;

    assign w_fetch_evt = !i_redirect && !i_stall && (w_ack_take || (r_state == S_HOLD));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_fetch_evt && (r_fetch_cnt != 16'hFFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            if (i_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign o_perf_fetch_cnt = r_fetch_cnt;
    assign o_perf_stall_cnt = r_stall_cnt;
`else
    assign o_perf_fetch_cnt = '0;
    assign o_perf_stall_cnt = '0;
`endif

endmodule
